// File: rtl/sync_link_pkg.sv
// Shared definitions for the 1101-sync serial link (transmitter and detector).
package sync_link_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      DATA = 2'd2,
      GAP  = 2'd3
   } tx_state_t;

   localparam logic [3:0]  SYNC_PATTERN = 4'b1101;
   localparam int unsigned SYNC_LEN     = 4;

   // Phase counter width: enough for the longest phase, plus one bit of headroom.
   function automatic int unsigned cnt_width(input int unsigned width, input int unsigned gap);
      int unsigned m;
      m = SYNC_LEN;
      if (width > m) m = width;
      if (gap > m)   m = gap;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter with zero flag; sequences the SYNC/DATA/GAP phases.
module phase_counter #(
   parameter int unsigned CW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          dec,
   output logic [CW-1:0] count,
   output logic          zero
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (dec && !zero)
         count <= count - CW'(1);
   end

   assign zero = (count == '0);

endmodule

// File: rtl/sync_frame_tx.sv
// Frame transmitter: accepts a word on valid/ready and emits 1101, the word MSB-first,
// then GAP_LEN zeros, one bit per clock on a registered serial line.
module sync_frame_tx
   import sync_link_pkg::*;
#(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned GAP_LEN = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             sout,
   output logic             busy,
   output logic             tx_done
);

   localparam int unsigned CW = cnt_width(WIDTH, GAP_LEN);

   tx_state_t        state, state_n;
   logic [WIDTH-1:0] sreg, sreg_n;
   logic             sout_n, busy_n, done_n;
   logic             load, dec, zero;
   logic [CW-1:0]    load_val, count;

   assign in_ready = (state == IDLE);

   phase_counter #(.CW(CW)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (load_val),
      .dec      (dec),
      .count    (count),
      .zero     (zero)
   );

   // Outputs are registered, so this block computes the bit for the *next* cycle
   // from the state being entered and the counter value it will hold.
   always_comb begin
      state_n  = state;
      sreg_n   = sreg;
      sout_n   = 1'b0;
      done_n   = 1'b0;
      load     = 1'b0;
      load_val = '0;
      dec      = 1'b0;
      unique case (state)
         IDLE: begin
            if (in_valid) begin
               state_n  = SYNC;
               sreg_n   = in_data;
               load     = 1'b1;
               load_val = CW'(SYNC_LEN - 1);
               sout_n   = SYNC_PATTERN[SYNC_LEN-1];
            end
         end
         SYNC: begin
            if (zero) begin
               state_n  = DATA;
               load     = 1'b1;
               load_val = CW'(WIDTH - 1);
               sout_n   = sreg[WIDTH-1];
               done_n   = (WIDTH == 1);
            end else begin
               dec    = 1'b1;
               sout_n = SYNC_PATTERN[count[1:0] - 2'd1];
            end
         end
         DATA: begin
            sreg_n = sreg << 1;
            if (zero) begin
               if (GAP_LEN == 0) begin
                  state_n = IDLE;
               end else begin
                  state_n  = GAP;
                  load     = 1'b1;
                  load_val = CW'(GAP_LEN) - CW'(1);
               end
            end else begin
               dec    = 1'b1;
               sout_n = sreg_n[WIDTH-1];
               done_n = (count == CW'(1));
            end
         end
         GAP: begin
            if (zero)
               state_n = IDLE;
            else
               dec = 1'b1;
         end
         default: state_n = IDLE;
      endcase
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         sreg    <= '0;
         sout    <= 1'b0;
         busy    <= 1'b0;
         tx_done <= 1'b0;
      end else begin
         state   <= state_n;
         sreg    <= sreg_n;
         sout    <= sout_n;
         busy    <= busy_n;
         tx_done <= done_n;
      end
   end

endmodule

// File: tb/tb_sync_frame_tx.sv
// Bench for sync_frame_tx: two configurations (8/2 and 1/0) against a frame-queue reference model.
module tb_sync_frame_tx;

   localparam int unsigned WA = 8;
   localparam int unsigned GA = 2;

   logic          clk;
   logic          rst_n;
   logic [WA-1:0] da;
   logic          va, ra, sa, ba, ta;
   logic [0:0]    db;
   logic          vb, rb, sb, bb, tdb;

   sync_frame_tx #(.WIDTH(WA), .GAP_LEN(GA)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_data(da), .in_valid(va),
      .in_ready(ra), .sout(sa), .busy(ba), .tx_done(ta)
   );

   sync_frame_tx #(.WIDTH(1), .GAP_LEN(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_data(db), .in_valid(vb),
      .in_ready(rb), .sout(sb), .busy(bb), .tx_done(tdb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int errors = 0;
   int checks = 0;

   // Each model entry is {done_flag, serial_bit} for one line cycle of the frame.
   bit [1:0] qa[$];
   bit [1:0] qb[$];
   int       acc_a = 0, acc_b = 0, dn_a = 0, dn_b = 0, cyc = 0;
   logic [3:0] hist = '0;
   logic       z_now = 1'b0;
   logic [3:0] sync_pat = 4'b1101;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      bit [1:0] ea, eb;
      @(posedge clk);
      if (!rst_n) begin
         qa.delete();
         qb.delete();
      end else begin
         if (qa.size() > 0)
            void'(qa.pop_front());
         else if (va) begin
            for (int i = 3; i >= 0; i--) qa.push_back({1'b0, sync_pat[i]});
            for (int i = WA - 1; i >= 0; i--) qa.push_back({(i == 0), da[i]});
            for (int i = 0; i < GA; i++) qa.push_back(2'b00);
            acc_a++;
         end
         if (qb.size() > 0)
            void'(qb.pop_front());
         else if (vb) begin
            for (int i = 3; i >= 0; i--) qb.push_back({1'b0, sync_pat[i]});
            qb.push_back({1'b1, db[0]});
            acc_b++;
         end
      end
      #1;
      ea = (qa.size() > 0) ? qa[0] : 2'b00;
      eb = (qb.size() > 0) ? qb[0] : 2'b00;
      check("a_sout",  sa,  ea[0]);
      check("a_done",  ta,  ea[1]);
      check("a_busy",  ba,  qa.size() > 0);
      check("a_ready", ra,  qa.size() == 0);
      check("b_sout",  sb,  eb[0]);
      check("b_done",  tdb, eb[1]);
      check("b_busy",  bb,  qb.size() > 0);
      check("b_ready", rb,  qb.size() == 0);
      if (ta)  dn_a++;
      if (tdb) dn_b++;
      z_now = (hist == 4'b1101);
      hist  = {hist[2:0], sa};
      cyc++;
   endtask

   initial begin
      logic [13:0] vec;
      logic [4:0]  vb5;
      int          didx, r1, r2, rdy, a0, d0, rises, zhits, rise;
      logic        pb;

      rst_n = 1'b1; va = 1'b0; vb = 1'b0; da = '0; db = '0;
      #1 rst_n = 1'b0;
      #2;
      check("rst_sout", sa, 1'b0);
      check("rst_busy", ba, 1'b0);
      check("rst_done", ta, 1'b0);
      check("rst_ready", ra, 1'b1);
      step();
      #2 rst_n = 1'b1;
      step();

      // Basic frame with A5
      va = 1'b1; da = 8'hA5;
      step();
      va = 1'b0;
      vec = '0; didx = -1;
      for (int i = 0; i < 14; i++) begin
         if (i > 0) begin
            da = WA'($urandom);
            step();
         end
         vec = {vec[12:0], sa};
         if (ta) didx = i;
      end
      check("basic_bits", vec, 14'b11011010010100);
      check("basic_done_idx", didx, 11);
      step();
      check("basic_idle_sout", sa, 1'b0);

      // Back-to-back FF then 00 with valid held
      va = 1'b1; da = 8'hFF;
      step();
      r1 = cyc; r2 = -1; rdy = 0; pb = ba; da = 8'h00;
      for (int i = 0; i < 20; i++) begin
         step();
         if (r2 < 0 && ra) rdy++;
         if (ba && !pb && r2 < 0) r2 = cyc;
         pb = ba;
      end
      va = 1'b0;
      check("b2b_period", r2 - r1, 15);
      check("b2b_ready_cycles", rdy, 1);
      for (int i = 0; i < 16; i++) step();

      // Hold-off: valid raised mid-frame
      a0 = acc_a; rises = 0; pb = ba;
      va = 1'b1; da = 8'h11;
      step();
      if (ba && !pb) rises++;
      pb = ba; va = 1'b0;
      for (int i = 0; i < 3; i++) begin step(); pb = ba; end
      va = 1'b1; da = 8'h3C;
      for (int i = 0; i < 30 && acc_a < a0 + 2; i++) begin
         step();
         if (ba && !pb) rises++;
         pb = ba;
      end
      va = 1'b0;
      for (int i = 0; i < 16; i++) begin
         da = WA'($urandom);
         step();
         if (ba && !pb) rises++;
         pb = ba;
      end
      check("holdoff_words", acc_a - a0, 2);
      check("holdoff_frames", rises, 2);

      // WIDTH=1, GAP_LEN=0 instance
      vb = 1'b1; db = 1'b1;
      step();
      vb = 1'b0; vb5 = '0; didx = -1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         vb5 = {vb5[3:0], sb};
         if (tdb) didx = i;
      end
      check("w1_bits", vb5, 5'b11011);
      check("w1_done_idx", didx, 4);
      step();
      check("w1_idle_sout", sb, 1'b0);
      check("w1_idle_ready", rb, 1'b1);

      // Reset while data bit 3 is on the line
      va = 1'b1; da = 8'hA5;
      step();
      va = 1'b0;
      for (int i = 0; i < 8; i++) step();
      d0 = dn_a;
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_sout", sa, 1'b0);
      check("mid_rst_busy", ba, 1'b0);
      check("mid_rst_done", ta, 1'b0);
      check("mid_rst_ready", ra, 1'b1);
      qa.delete(); qb.delete();
      step(); step();
      #2 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) step();
      check("mid_rst_no_done", dn_a - d0, 0);
      va = 1'b1; da = 8'h5A;
      step();
      va = 1'b0;
      for (int i = 0; i < 16; i++) step();
      check("post_rst_done", dn_a - d0, 1);

      // Loopback into a 1101 detector, zero payloads
      hist = '0; zhits = 0; rise = -100; pb = ba; a0 = acc_a;
      va = 1'b1; da = 8'h00;
      for (int i = 0; i < 40; i++) begin
         if (acc_a >= a0 + 2) va = 1'b0;
         step();
         if (ba && !pb) rise = cyc;
         pb = ba;
         if (z_now) begin
            zhits++;
            check("loop_z_pos", cyc - rise, 4);
         end
      end
      va = 1'b0;
      check("loop_z_hits", zhits, 2);

      // Random traffic on both instances
      a0 = acc_a; d0 = dn_a; r1 = acc_b; r2 = dn_b;
      for (int i = 0; i < 400; i++) begin
         va = ($urandom_range(0, 2) == 0);
         vb = ($urandom_range(0, 1) == 0);
         da = WA'($urandom);
         db = 1'($urandom);
         step();
      end
      va = 1'b0; vb = 1'b0;
      for (int i = 0; i < 20; i++) step();
      check("rand_a_words", dn_a - d0, acc_a - a0);
      check("rand_b_words", dn_b - r2, acc_b - r1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
